// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage RV64 core.
// Sequences load-use stalls, taken-branch flushes (resolved in MEM) and
// multi-cycle EX occupancy (MUL/DIV), driving the write-enable and
// flush/bubble controls of PC, IF/ID, ID/EX and EX/MEM. Also keeps
// saturating counters of stall cycles and branch flushes.
module hazard_ctrl #(
  parameter int MC_LAT = 4  // EX occupancy of a multi-cycle op, 1..64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IFID_rs1,
  input  logic [4:0]  IFID_rs2,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_rd,
  input  logic        IDEX_mc,
  input  logic        branch_taken,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Write,
  output logic        IDEX_Bubble,
  output logic        EXMEM_Bubble,
  output logic        mc_busy,
  output logic        mc_done,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  // FSM encoding
  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MC_BUSY = 1'b1;

  // A single-cycle op never enters MC_BUSY; otherwise the RUN entry cycle
  // is the first of MC_LAT EX cycles, so the down-counter starts at
  // MC_LAT-2 and the cnt==0 cycle is the final (mc_done) cycle.
  localparam bit         MC_MULTI = (MC_LAT > 1);
  localparam logic [5:0] MC_INIT  = MC_MULTI ? 6'(MC_LAT - 2) : 6'd0;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [0:0]  r_state;
  logic [0:0]  w_state_next;
  logic [5:0]  r_cnt;
  logic [5:0]  w_cnt_next;
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  // ---------------------------------------------------------------------
  // Load-use detection: both source fields are always compared, since
  // the decoder does not tell us which sources the ID instruction uses.
  // ---------------------------------------------------------------------
  logic [9:0] w_srcs;
  logic [1:0] w_src_match;
  logic       w_lu;

  assign w_srcs = {IFID_rs2, IFID_rs1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
      assign w_src_match[gi] = (IDEX_rd == w_srcs[gi*5 +: 5]);
    end
  endgenerate

  assign w_lu = IDEX_MemRead & (IDEX_rd != 5'd0) & (|w_src_match);

  // Decoded per-cycle events after priority resolution
  logic w_in_mc;
  logic w_mc_enter;
  logic w_mc_last;
  logic w_mc_hold;
  logic w_mc_single;
  logic w_lu_stall;

  assign w_in_mc     = (r_state == ST_MC_BUSY);
  assign w_mc_enter  = !branch_taken && !w_in_mc && IDEX_mc && MC_MULTI;
  assign w_mc_single = !branch_taken && !w_in_mc && IDEX_mc && !MC_MULTI;
  assign w_mc_hold   = !branch_taken && w_in_mc && (r_cnt != 6'd0);
  assign w_mc_last   = !branch_taken && w_in_mc && (r_cnt == 6'd0);
  // Load-use only matters in RUN; in MC_BUSY the stall already holds ID.
  assign w_lu_stall  = !branch_taken && !w_in_mc && !IDEX_mc && w_lu;

  // Combinational control outputs from state, cnt and inputs
  always_comb begin
    PCWrite      = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Write   = 1'b1;
    IDEX_Bubble  = 1'b0;
    EXMEM_Bubble = 1'b0;
    mc_busy      = 1'b0;
    mc_done      = 1'b0;
    if (!reset) begin
      if (branch_taken) begin
        // Squash the three younger slots; the PC takes the branch target.
        IFID_Flush   = 1'b1;
        IDEX_Bubble  = 1'b1;
        EXMEM_Bubble = 1'b1;
      end else if (w_mc_enter || w_mc_hold) begin
        // Freeze the front end and feed MEM bubbles while EX is occupied.
        PCWrite      = 1'b0;
        IFID_Write   = 1'b0;
        IDEX_Write   = 1'b0;
        EXMEM_Bubble = 1'b1;
        mc_busy      = 1'b1;
      end else if (w_mc_last) begin
        // Final EX cycle: release the stall and let the op move to MEM.
        mc_busy = 1'b1;
        mc_done = 1'b1;
      end else if (w_mc_single) begin
        mc_done = 1'b1;
      end else if (w_lu_stall) begin
        // Hold PC and IF/ID, push one bubble into EX.
        PCWrite     = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Bubble = 1'b1;
      end
    end
  end

  // Next-state and down-counter logic
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (branch_taken) begin
      w_state_next = ST_RUN;
      w_cnt_next   = 6'd0;
    end else if (w_mc_enter) begin
      w_state_next = ST_MC_BUSY;
      w_cnt_next   = MC_INIT;
    end else if (w_mc_hold) begin
      w_cnt_next   = r_cnt - 6'd1;
    end else if (w_mc_last) begin
      w_state_next = ST_RUN;
      w_cnt_next   = 6'd0;
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_cnt   <= 6'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= 16'd0;
      r_flush_count  <= 16'd0;
    end else begin
      if (!PCWrite && (r_stall_cycles != CNT_MAX))
        r_stall_cycles <= r_stall_cycles + 16'd1;
      if (branch_taken && (r_flush_count != CNT_MAX))
        r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl. A second instance with
// MC_LAT=1 shares the stimulus to cover the single-cycle multi-cycle case.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  IFID_rs1;
  logic [4:0]  IFID_rs2;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_rd;
  logic        IDEX_mc;
  logic        branch_taken;

  logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Write;
  logic        IDEX_Bubble, EXMEM_Bubble, mc_busy, mc_done;
  logic [15:0] stall_cycles, flush_count;

  logic        PCWrite1, IFID_Write1, IFID_Flush1, IDEX_Write1;
  logic        IDEX_Bubble1, EXMEM_Bubble1, mc_busy1, mc_done1;
  logic [15:0] stall_cycles1, flush_count1;

  int total = 0;
  int bad   = 0;

  // ctl bit order: PCWrite IFID_Write IFID_Flush IDEX_Write
  //                IDEX_Bubble EXMEM_Bubble mc_busy mc_done
  logic [7:0] ctl, ctl1;
  assign ctl  = {PCWrite, IFID_Write, IFID_Flush, IDEX_Write,
                 IDEX_Bubble, EXMEM_Bubble, mc_busy, mc_done};
  assign ctl1 = {PCWrite1, IFID_Write1, IFID_Flush1, IDEX_Write1,
                 IDEX_Bubble1, EXMEM_Bubble1, mc_busy1, mc_done1};

  localparam logic [7:0] C_DEF = 8'b1101_0000;
  localparam logic [7:0] C_LU  = 8'b0001_1000;
  localparam logic [7:0] C_MCS = 8'b0000_0110;
  localparam logic [7:0] C_MCD = 8'b1101_0011;
  localparam logic [7:0] C_BR  = 8'b1111_1100;
  localparam logic [7:0] C_MC1 = 8'b1101_0001;

  hazard_ctrl #(.MC_LAT(4)) dut (
    .clk(clk), .reset(reset),
    .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_rd(IDEX_rd), .IDEX_mc(IDEX_mc),
    .branch_taken(branch_taken),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Write(IDEX_Write), .IDEX_Bubble(IDEX_Bubble),
    .EXMEM_Bubble(EXMEM_Bubble), .mc_busy(mc_busy), .mc_done(mc_done),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  hazard_ctrl #(.MC_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_rd(IDEX_rd), .IDEX_mc(IDEX_mc),
    .branch_taken(branch_taken),
    .PCWrite(PCWrite1), .IFID_Write(IFID_Write1), .IFID_Flush(IFID_Flush1),
    .IDEX_Write(IDEX_Write1), .IDEX_Bubble(IDEX_Bubble1),
    .EXMEM_Bubble(EXMEM_Bubble1), .mc_busy(mc_busy1), .mc_done(mc_done1),
    .stall_cycles(stall_cycles1), .flush_count(flush_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic mc, input logic br);
    IDEX_MemRead = mr;
    IDEX_rd      = rd;
    IFID_rs1     = rs1;
    IFID_rs2     = rs2;
    IDEX_mc      = mc;
    branch_taken = br;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    // Hazard present while in reset: outputs must still be the defaults.
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    chk("reset_ctl", 32'(ctl), 32'(C_DEF));
    tick();
    tick();
    chk("reset_stall", 32'(stall_cycles), 32'd0);
    chk("reset_flush", 32'(flush_count), 32'd0);
    reset = 1'b0;

    // x0 destination: never a hazard
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("rd_x0_ctl", 32'(ctl), 32'(C_DEF));
    tick();
    // load, no matching source
    drive(1'b1, 5'd7, 5'd3, 5'd4, 1'b0, 1'b0);
    chk("nomatch_ctl", 32'(ctl), 32'(C_DEF));
    tick();
    // matching source but not a load
    drive(1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0);
    chk("notload_ctl", 32'(ctl), 32'(C_DEF));
    tick();
    chk("nostall_cnt", 32'(stall_cycles), 32'd0);

    // Load-use via rs2
    drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0);
    chk("lu_rs2_ctl", 32'(ctl), 32'(C_LU));
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
    chk("lu_after_ctl", 32'(ctl), 32'(C_DEF));
    chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);
    // Load-use via rs1
    drive(1'b1, 5'd9, 5'd9, 5'd2, 1'b0, 1'b0);
    chk("lu_rs1_ctl", 32'(ctl), 32'(C_LU));
    tick();
    chk("lu2_stall_cnt", 32'(stall_cycles), 32'd2);

    // Multi-cycle op, held for back-to-back ops
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("mc_c1_ctl", 32'(ctl), 32'(C_MCS));
    chk("mc1_ctl", 32'(ctl1), 32'(C_MC1));
    tick();
    chk("mc_c2_ctl", 32'(ctl), 32'(C_MCS));
    tick();
    chk("mc_c3_ctl", 32'(ctl), 32'(C_MCS));
    tick();
    chk("mc_c4_ctl", 32'(ctl), 32'(C_MCD));
    chk("mc_c4_stall", 32'(stall_cycles), 32'd5);
    tick();
    // Second op restarts the stall immediately
    chk("mc_b2b_ctl", 32'(ctl), 32'(C_MCS));
    chk("mc1_stall", 32'(stall_cycles1), 32'd2);
    tick();
    // Branch in the second EX cycle aborts the op
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    chk("br_abort_ctl", 32'(ctl), 32'(C_BR));
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("br_after_ctl", 32'(ctl), 32'(C_DEF));
    chk("br_flush_cnt", 32'(flush_count), 32'd1);
    chk("br_stall_cnt", 32'(stall_cycles), 32'd6);

    // Branch together with load-use: flush only
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
    chk("br_lu_ctl", 32'(ctl), 32'(C_BR));
    tick();
    chk("br_lu_stall", 32'(stall_cycles), 32'd6);
    chk("br_lu_flush", 32'(flush_count), 32'd2);

    // Branch together with multi-cycle entry: no MC_BUSY afterwards
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    chk("br_mc_ctl", 32'(ctl), 32'(C_BR));
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("br_mc_after", 32'(ctl), 32'(C_DEF));
    chk("br_mc_flush", 32'(flush_count), 32'd3);
    chk("br_mc_stall", 32'(stall_cycles), 32'd6);

    // Saturation of stall_cycles via a held load-use hazard
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_stall", 32'(stall_cycles), 32'hFFFF);
    tick();
    chk("sat_hold", 32'(stall_cycles), 32'hFFFF);

    // Reset in the middle of MC_BUSY
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    tick();
    tick();
    chk("mc_mid_ctl", 32'(ctl), 32'(C_MCS));
    reset = 1'b1;
    #1;
    chk("rst_mid_ctl", 32'(ctl), 32'(C_DEF));
    tick();
    reset = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("rst_run_ctl", 32'(ctl), 32'(C_DEF));
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    chk("rst_flush", 32'(flush_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
